cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Hardwired T-state sequencer for the SAP-BR CPU. It generates the T-state count and the 7-bit microcode address {opcode, T-state} that drives the microcode ROM. It also:
- terminates instructions early on a microcode request or a failed conditional jump,
- halts on the microcode halt bit,
- counts retired instructions,
- optionally single-steps from a push button.

It sits between the instruction register, the flags register and the microcode ROM, and replaces the free-running T-state counter.

## Interface
Parameters:
- T_MAX, 5: T-states per instruction (2..8); T_STATE wraps after T_MAX-1
- OPC_W, 4: opcode width

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- OPCODE  in  OPC_W  IR opcode nibble, valid from T2
- FLAG_Z  in  1  zero flag from flags register
- FLAG_C  in  1  carry flag from flags register
- HLT_REQ  in  1  microcode HLT bit for current UADDR
- END_REQ  in  1  microcode end-of-instruction bit for current UADDR
- STEP_MODE  in  1  1 = single-step mode (used only with macro)
- STEP_BTN  in  1  raw asynchronous step push button (used only with macro)
- T_STATE  out  3  current T-state
- UADDR  out  OPC_W+3  microcode address = {OPCODE, T_STATE}, combinational
- FETCH  out  1  high while T_STATE is 0 or 1
- JMP_OK  out  1  combinational jump qualifier: 1 for JMP; FLAG_C for JC; FLAG_Z for JZ; 0 otherwise
- HALTED  out  1  sequencer is in HALT
- INSTR_DONE  out  1  one-cycle registered pulse, high in the T0 cycle following a retirement
- INSTR_CNT  out  8  count of retired instructions, wraps 255 -> 0

## Operation
FSM states: RUN, WAIT (macro only), HALT.

Reset:
- State = RUN, T_STATE = 0, HALTED = 0, INSTR_DONE = 0, INSTR_CNT = 0.
- FETCH = 1; UADDR = {OPCODE, 3'd0}.

RUN, evaluated each rising edge, in priority order:
1. HLT_REQ = 1 -> HALT. T_STATE is held and INSTR_CNT is not incremented.
2. Retire condition true -> T_STATE = 0, INSTR_CNT += 1, INSTR_DONE = 1 next cycle. The retire condition is any of:
   - END_REQ = 1 with T_STATE >= 2,
   - T_STATE = 2 with OPCODE = JC/JZ and JMP_OK = 0,
   - T_STATE = T_MAX-1.
3. Otherwise T_STATE += 1.

Fetch protection: END_REQ at T0/T1 is ignored.

HALT:
- T_STATE and UADDR are frozen; HALTED = 1.
- Exit only through RESET. HLT_REQ and STEP_BTN are ignored.

Arithmetic:
- T_STATE is 3-bit unsigned.
- INSTR_CNT is 8-bit modulo 256.

## Timing
- UADDR, FETCH and JMP_OK are combinational from registered T_STATE and the inputs. Microcode outputs are valid within the same cycle.
- Zero latency from a T_STATE change to UADDR.
- One cycle from a retire edge to the INSTR_DONE pulse.
- HALTED rises one cycle after HLT_REQ is sampled.
- RESET asserted mid-instruction returns to T0/RUN on the next edge, regardless of state.
- Simultaneous events:
  - HLT_REQ with END_REQ -> halt wins, no retire.
  - HLT_REQ at T_MAX-1 -> halt, no wrap.

## Configuration
Macro: SEQ_SINGLE_STEP_EN.

Defined:
- STEP_BTN passes through a 2-flop synchronizer and a rising-edge detector.
- With STEP_MODE = 1, RUN advances one T-state and then enters WAIT.
- WAIT returns to RUN for exactly one evaluation per detected STEP_BTN rising edge. A held button gives one step only.
- Entry into WAIT happens only after the RUN evaluation, so HLT_REQ still takes effect.
- STEP_MODE = 0 while in WAIT -> RUN on the next edge.
- Step edges in HALT are ignored.
- Synchronizer flops reset to 0.

Undefined:
- No WAIT state.
- STEP_MODE and STEP_BTN are ignored; the ports remain present.

## Structure
- Package sap_pkg holds:
  - opcode constants: OPC_JMP = 4'h6, OPC_JC = 4'h7, OPC_JZ = 4'h8,
  - enumerated state type seq_state_t {RUN, WAIT, HALT}.
- Sub-module step_sync (2-flop synchronizer + rising-edge detector) is instantiated only under SEQ_SINGLE_STEP_EN.

## Test plan
- T_MAX = 5, OPCODE = 4'h1, no END/HLT, 10 clocks -> T_STATE 0,1,2,3,4,0,1,2,3,4. INSTR_DONE pulses at cycles 5 and 10. INSTR_CNT = 2.
- OPCODE = OPC_JZ, FLAG_Z = 0 at T2 -> next T_STATE = 0, INSTR_CNT += 1. With FLAG_Z = 1 -> T_STATE = 3 and JMP_OK = 1.
- END_REQ = 1 held for all T-states -> retire at T2, never at T0/T1. Sequence is 0,1,2,0.
- HLT_REQ at T3 together with END_REQ -> HALTED = 1 and T_STATE stays at 3 for 20 cycles with INSTR_CNT unchanged. A RESET pulse then gives T_STATE = 0, HALTED = 0, INSTR_CNT = 0.
- Run 256 instructions -> INSTR_CNT wraps to 0. RESET at T3 mid-instruction -> T_STATE = 0 on the next edge.
- With SEQ_SINGLE_STEP_EN and STEP_MODE = 1: STEP_BTN held high for 10 cycles -> T_STATE advances by exactly one. Three separate presses -> three advances.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// sap_pkg: opcode constants and sequencer state type shared by the SAP-BR CPU control path.
package sap_pkg;

    localparam logic [3:0] OPC_JMP = 4'h6;
    localparam logic [3:0] OPC_JC  = 4'h7;
    localparam logic [3:0] OPC_JZ  = 4'h8;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> IR/flags/microcode-ROM bundle; master is the sequencer, slave is the surrounding datapath.
interface cpu_sequencer_if #(
    parameter int OPC_W = 4
);

    logic [OPC_W-1:0] OPCODE;
    logic             FLAG_Z;
    logic             FLAG_C;
    logic             HLT_REQ;
    logic             END_REQ;
    logic             STEP_MODE;
    logic             STEP_BTN;
    logic [2:0]       T_STATE;
    logic [OPC_W+2:0] UADDR;
    logic             FETCH;
    logic             JMP_OK;
    logic             HALTED;
    logic             INSTR_DONE;
    logic [7:0]       INSTR_CNT;

    modport master (
        input  OPCODE, FLAG_Z, FLAG_C, HLT_REQ, END_REQ, STEP_MODE, STEP_BTN,
        output T_STATE, UADDR, FETCH, JMP_OK, HALTED, INSTR_DONE, INSTR_CNT
    );

    modport slave (
        output OPCODE, FLAG_Z, FLAG_C, HLT_REQ, END_REQ, STEP_MODE, STEP_BTN,
        input  T_STATE, UADDR, FETCH, JMP_OK, HALTED, INSTR_DONE, INSTR_CNT
    );

endinterface

// File: rtl/cpu_sequencer_step_sync.sv
// step_sync: 2-flop synchronizer plus rising-edge detector for the raw step push button.
// Only compiled when SEQ_SINGLE_STEP_EN is defined.
`ifdef SEQ_SINGLE_STEP_EN
module step_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn_async;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule
`endif

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: hardwired T-state sequencer driving the microcode ROM address {OPCODE, T_STATE}.
// Optional single-step mode (WAIT state + step_sync) enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer
    import sap_pkg::*;
#(
    parameter int T_MAX = 5,
    parameter int OPC_W = 4
) (
    input logic            CLOCK,
    input logic            RESET,
    cpu_sequencer_if.master bus
);

    localparam logic [2:0] T_LAST = 3'(T_MAX - 1);

    seq_state_t state;
    logic [2:0] t_state;
    logic       halted;
    logic       instr_done;
    logic [7:0] instr_cnt;
    logic       jmp_ok;
    logic       is_cond;
    logic       retire;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_rise;

    step_sync u_step_sync (
        .clk       (CLOCK),
        .rst       (RESET),
        .btn_async (bus.STEP_BTN),
        .rise      (step_rise)
    );
`else
    logic unused_step;
    assign unused_step = bus.STEP_MODE ^ bus.STEP_BTN;
`endif

    always_comb begin
        is_cond = (bus.OPCODE == OPC_W'(OPC_JC)) || (bus.OPCODE == OPC_W'(OPC_JZ));
        jmp_ok  = 1'b0;
        if (bus.OPCODE == OPC_W'(OPC_JMP))
            jmp_ok = 1'b1;
        else if (bus.OPCODE == OPC_W'(OPC_JC))
            jmp_ok = bus.FLAG_C;
        else if (bus.OPCODE == OPC_W'(OPC_JZ))
            jmp_ok = bus.FLAG_Z;
        // END_REQ during fetch (T0/T1) must not cut the instruction short
        retire = (bus.END_REQ && (t_state >= 3'd2))
              || ((t_state == 3'd2) && is_cond && !jmp_ok)
              || (t_state == T_LAST);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= RUN;
            t_state    <= 3'd0;
            halted     <= 1'b0;
            instr_done <= 1'b0;
            instr_cnt  <= 8'd0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.HLT_REQ) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        if (retire) begin
                            t_state    <= 3'd0;
                            instr_cnt  <= instr_cnt + 8'd1;
                            instr_done <= 1'b1;
                        end else begin
                            t_state <= t_state + 3'd1;
                        end
`ifdef SEQ_SINGLE_STEP_EN
                        if (bus.STEP_MODE)
                            state <= WAIT;
`endif
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                WAIT: begin
                    if (!bus.STEP_MODE || step_rise)
                        state <= RUN;
                end
`endif
                HALT: begin
                    state <= HALT;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.T_STATE    = t_state;
    assign bus.UADDR      = {bus.OPCODE, t_state};
    assign bus.FETCH      = (t_state < 3'd2);
    assign bus.JMP_OK     = jmp_ok;
    assign bus.HALTED     = halted;
    assign bus.INSTR_DONE = instr_done;
    assign bus.INSTR_CNT  = instr_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed scenarios plus random stimulus against a cycle reference model.
module tb_cpu_sequencer;
    import sap_pkg::*;

    localparam int T_MAX = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cpu_sequencer_if #(.OPC_W(4)) bus();

    cpu_sequencer #(.T_MAX(T_MAX), .OPC_W(4)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [6:0] uaddr;
        logic       fetch;
        logic       jmp_ok;
        logic       halted;
        logic       done;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: architectural view of the sequencer
    int m_t     = 0;
    int m_cnt   = 0;
    bit m_halt  = 0;
    bit m_done  = 0;
    bit m_known = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle, compare DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("t_state",    int'(bus.T_STATE),    e.t);
                check("uaddr",      int'(bus.UADDR),      int'(e.uaddr));
                check("fetch",      int'(bus.FETCH),      int'(e.fetch));
                check("jmp_ok",     int'(bus.JMP_OK),     int'(e.jmp_ok));
                check("halted",     int'(bus.HALTED),     int'(e.halted));
                check("instr_done", int'(bus.INSTR_DONE), int'(e.done));
                check("instr_cnt",  int'(bus.INSTR_CNT),  e.cnt);
            end
        end
    end

    task automatic cyc(input logic [3:0] opc, input logic z, input logic c,
                       input logic e, input logic h, input logic r);
        exp_t x;
        bit   jok;
        bit   ret;
        @(negedge clk);
        rst         = r;
        bus.OPCODE  = opc;
        bus.FLAG_Z  = z;
        bus.FLAG_C  = c;
        bus.END_REQ = e;
        bus.HLT_REQ = h;
        jok = (opc == OPC_JMP) || (opc == OPC_JC && c) || (opc == OPC_JZ && z);
        if (m_known) begin
            x.t      = m_t;
            x.uaddr  = {opc, 3'(m_t)};
            x.fetch  = (m_t < 2);
            x.jmp_ok = jok;
            x.halted = m_halt;
            x.done   = m_done;
            x.cnt    = m_cnt;
            sb_q.push_back(x);
        end
        if (r) begin
            m_t = 0; m_cnt = 0; m_halt = 0; m_done = 0; m_known = 1;
        end else if (m_known) begin
            m_done = 0;
            if (m_halt) begin
                // frozen until reset
            end else if (h) begin
                m_halt = 1;
            end else begin
                ret = (e && m_t >= 2)
                   || (m_t == 2 && (opc == OPC_JC || opc == OPC_JZ) && !jok)
                   || (m_t == T_MAX - 1);
                if (ret) begin
                    m_t = 0; m_cnt = (m_cnt + 1) % 256; m_done = 1;
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
    endtask

    initial begin
        int guard;
        bus.OPCODE = 4'h0; bus.FLAG_Z = 1'b0; bus.FLAG_C = 1'b0;
        bus.END_REQ = 1'b0; bus.HLT_REQ = 1'b0;
        bus.STEP_MODE = 1'b0; bus.STEP_BTN = 1'b0;

        // Free run: two full instructions
        cyc(4'h1, 0, 0, 0, 0, 1);
        repeat (11) cyc(4'h1, 0, 0, 0, 0, 0);

        // JZ not taken retires at T2, then taken continues to T3
        cyc(OPC_JZ, 0, 0, 0, 0, 1);
        repeat (3) cyc(OPC_JZ, 0, 0, 0, 0, 0);
        repeat (3) cyc(OPC_JZ, 1, 0, 0, 0, 0);
        repeat (3) cyc(OPC_JC, 0, 1, 0, 0, 0);
        repeat (3) cyc(OPC_JC, 0, 0, 0, 0, 0);

        // END_REQ held: retire at T2 only
        cyc(4'h3, 0, 0, 1, 1, 1);
        repeat (8) cyc(4'h3, 0, 0, 1, 0, 0);

        // Halt at T3 together with END_REQ, frozen 20 cycles, then reset
        cyc(4'h2, 0, 0, 0, 0, 1);
        repeat (3) cyc(4'h2, 0, 0, 0, 0, 0);
        cyc(4'h2, 0, 0, 1, 1, 0);
        repeat (20) cyc(4'h2, 0, 0, 1, 1'($urandom_range(0, 1)), 0);
        cyc(4'h2, 0, 0, 0, 0, 1);
        repeat (3) cyc(4'h2, 0, 0, 0, 0, 0);

        // 256 instructions wrap the counter; then reset at T3
        cyc(4'h4, 0, 0, 0, 0, 1);
        repeat (256 * T_MAX + 3) cyc(4'h4, 0, 0, 0, 0, 0);
        cyc(4'h4, 0, 0, 0, 0, 1);
        repeat (3) cyc(4'h4, 0, 0, 0, 0, 0);

        // Randomized traffic
        repeat (3000) begin
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 79) == 0));
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: held button gives one step, three presses give three
        @(negedge clk);
        rst = 1'b1; bus.STEP_MODE = 1'b1; bus.STEP_BTN = 1'b0;
        bus.OPCODE = 4'h1; bus.END_REQ = 1'b0; bus.HLT_REQ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #2 check("step_idle", int'(bus.T_STATE), 1);
        bus.STEP_BTN = 1'b1;
        repeat (10) @(negedge clk);
        bus.STEP_BTN = 1'b0;
        repeat (6) @(negedge clk);
        #2 check("step_hold", int'(bus.T_STATE), 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.STEP_BTN = 1'b1;
            repeat (2) @(negedge clk);
            bus.STEP_BTN = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #2 check("step_three", int'(bus.T_STATE), (2 + 3) % T_MAX);
        bus.STEP_MODE = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
